pes_cg_ctrl: RTL

- Clock-gating controller for the team's integrated clock-gate cells.
- Generates one registered gate enable (`cg_en`) per gated domain; each `cg_en` drives the ICG enable input of that domain.
- Shuts a domain's clock after a programmable run of idle cycles.
- Wakes it on activity or on an explicit 4-phase request/acknowledge from a requester.
- Sits between the per-domain activity monitors and the ICG cells.

---
 rtl/pes_cg_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/pes_cg_ctrl.sv
// pes_cg_ctrl: clock-gating controller producing one registered ICG enable per
// gated domain. A domain is gated off after IDLE_CYCLES consecutive idle edges
// and woken by activity, a 4-phase wake request or the global force_on.
// Optional build macro: CG_STATS_EN adds gate_cnt, a saturating per-domain
// count of RUN->OFF transitions (one byte per domain).
module pes_cg_ctrl #(
    parameter int unsigned N_DOM       = 2,
    parameter int unsigned IDLE_CYCLES = 8,
    parameter int unsigned WAKE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_DOM-1:0] busy,
    input  logic [N_DOM-1:0] wake_req,
    input  logic             force_on,
    output logic [N_DOM-1:0] cg_en,
    output logic [N_DOM-1:0] wake_ack,
    output logic [N_DOM-1:0] gated
`ifdef CG_STATS_EN
    ,
    output logic [N_DOM*8-1:0] gate_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_OFF,
        ST_WAKE
    } state_t;

    localparam logic [7:0] IDLE_LAST = 8'(IDLE_CYCLES - 1);
    localparam logic [7:0] WAKE_LAST = 8'(WAKE_CYCLES - 1);

    for (genvar i = 0; i < N_DOM; i++) begin : g_dom
        state_t     state_q, state_d;
        logic [7:0] cnt_q, cnt_d;
        logic       ack_q, ack_d;
        logic       cg_en_q;
        logic       gated_q;
        logic       idle;
        logic       wake_evt;

        // An outstanding ack keeps the domain awake until the requester finishes
        assign idle     = ~busy[i] & ~wake_req[i] & ~ack_q & ~force_on;
        assign wake_evt = busy[i] | wake_req[i] | force_on;

        // Next-state, counter and acknowledge logic for this domain
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            ack_d   = ack_q;
            unique case (state_q)
                ST_RUN: begin
                    if (!idle) begin
                        cnt_d = '0;
                    end else if (cnt_q == IDLE_LAST) begin
                        state_d = ST_OFF;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                ST_OFF: begin
                    if (wake_evt) begin
                        state_d = ST_WAKE;
                        cnt_d   = '0;
                    end
                end
                ST_WAKE: begin
                    if (cnt_q == WAKE_LAST) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            endcase

            if (!wake_req[i]) begin
                ack_d = 1'b0;
            end else if (state_q == ST_RUN ||
                         (state_q == ST_WAKE && cnt_q == WAKE_LAST)) begin
                ack_d = 1'b1;
            end
        end

        // State register; enables are registered from the next state so cg_en
        // rises on the same edge that leaves OFF
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q <= ST_RUN;
                cnt_q   <= '0;
                ack_q   <= 1'b0;
                cg_en_q <= 1'b1;
                gated_q <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                ack_q   <= ack_d;
                cg_en_q <= (state_d != ST_OFF);
                gated_q <= (state_d == ST_OFF);
            end
        end

        assign cg_en[i]    = cg_en_q;
        assign wake_ack[i] = ack_q;
        assign gated[i]    = gated_q;

`ifdef CG_STATS_EN
        logic [7:0] gcnt_q;

        // Saturating count of RUN->OFF transitions
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                gcnt_q <= '0;
            end else if (state_q == ST_RUN && state_d == ST_OFF && gcnt_q != 8'hFF) begin
                gcnt_q <= gcnt_q + 8'd1;
            end
        end

        assign gate_cnt[i*8 +: 8] = gcnt_q;
`endif
    end

endmodule
